// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the 1280x1024@60 raster timing generator.
package vga_timing_pkg;

    localparam int COORD_W   = 11;
    localparam int MAX_TOTAL = 2048;

    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP     = 48;
    localparam int DEF_H_SYNC   = 112;
    localparam int DEF_H_BP     = 248;
    localparam int DEF_V_ACTIVE = 1024;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 38;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_FRONT,
        ST_SYNC,
        ST_BACK
    } axis_state_e;

    function automatic bit timing_ok(input int active, input int fp, input int sync, input int bp);
        return (active > 0) && (fp > 0) && (sync > 0) && (bp > 0) &&
               ((active + fp + sync + bp) <= MAX_TOTAL);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus ACTIVE/FRONT/SYNC/BACK decode and sync level.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter bit POL    = 1'b1
) (
    input  logic               VGA_CLK,
    input  logic               reset,
    input  logic               cnt_en,
    output logic [COORD_W-1:0] count,
    output logic               wrap,
    output axis_state_e        state,
    output logic               sync
);

    localparam int     TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam coord_t LAST       = coord_t'(TOTAL - 1);
    localparam coord_t FP_START   = coord_t'(ACTIVE);
    localparam coord_t SYNC_START = coord_t'(ACTIVE + FP);
    localparam coord_t BP_START   = coord_t'(ACTIVE + FP + SYNC);

    generate
        if (!timing_ok(ACTIVE, FP, SYNC, BP)) begin : g_bad_params
            $error("vga_axis_counter: zero-width segment or total above 2048");
        end
    endgenerate

    assign wrap = cnt_en && (count == LAST);

    always_ff @(posedge VGA_CLK or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (cnt_en)
            count <= wrap ? '0 : count + coord_t'(1);
    end

    always_comb begin
        state = ST_ACTIVE;
        if (count >= BP_START)
            state = ST_BACK;
        else if (count >= SYNC_START)
            state = ST_SYNC;
        else if (count >= FP_START)
            state = ST_FRONT;
    end

    assign sync = (state == ST_SYNC) ? POL : !POL;

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: cascaded h/v axis counters with registered outputs.
// Optional VGA_TIMING_SYNC_DELAY_EN delays h_sync/v_sync/n_blank by one clock.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit H_POL    = 1'b1,
    parameter bit V_POL    = 1'b1
) (
    input  logic               VGA_CLK,
    input  logic               reset,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               disp_en,
    output logic               h_sync,
    output logic               v_sync,
    output logic               n_blank,
    output logic               frame_start
);

    coord_t      h_cnt, v_cnt;
    logic        h_wrap, v_wrap;
    axis_state_e h_state, v_state;
    logic        h_sync_lvl, v_sync_lvl;
    logic        visible;
    logic        origin_q;
    logic        hs_q, vs_q, nb_q;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP), .POL (H_POL)
    ) u_h (
        .VGA_CLK (VGA_CLK),
        .reset   (reset),
        .cnt_en  (1'b1),
        .count   (h_cnt),
        .wrap    (h_wrap),
        .state   (h_state),
        .sync    (h_sync_lvl)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP), .POL (V_POL)
    ) u_v (
        .VGA_CLK (VGA_CLK),
        .reset   (reset),
        .cnt_en  (h_wrap),
        .count   (v_cnt),
        .wrap    (v_wrap),
        .state   (v_state),
        .sync    (v_sync_lvl)
    );

    assign visible = (h_state == ST_ACTIVE) && (v_state == ST_ACTIVE);

    // origin_q mirrors (h_cnt==0 && v_cnt==0): counters only reach the origin
    // through reset or the combined wrap, so a flop replaces a 22-bit compare.
    always_ff @(posedge VGA_CLK or negedge reset) begin
        if (!reset) begin
            x           <= '0;
            y           <= '0;
            disp_en     <= 1'b0;
            frame_start <= 1'b0;
            origin_q    <= 1'b1;
            hs_q        <= !H_POL;
            vs_q        <= !V_POL;
            nb_q        <= 1'b0;
        end else begin
            x           <= h_cnt;
            y           <= v_cnt;
            disp_en     <= visible;
            frame_start <= origin_q;
            origin_q    <= v_wrap;
            hs_q        <= h_sync_lvl;
            vs_q        <= v_sync_lvl;
            nb_q        <= visible;
        end
    end

`ifdef VGA_TIMING_SYNC_DELAY_EN
    logic hs_d, vs_d, nb_d;

    // Extra stage lines the DAC strobes up with the colour generators' registered RGB.
    always_ff @(posedge VGA_CLK or negedge reset) begin
        if (!reset) begin
            hs_d <= !H_POL;
            vs_d <= !V_POL;
            nb_d <= 1'b0;
        end else begin
            hs_d <= hs_q;
            vs_d <= vs_q;
            nb_d <= nb_q;
        end
    end

    assign h_sync  = hs_d;
    assign v_sync  = vs_d;
    assign n_blank = nb_d;
`else
    assign h_sync  = hs_q;
    assign v_sync  = vs_q;
    assign n_blank = nb_q;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench: default-timing and tiny-timing instances checked against an arithmetic raster model.
module tb_vga_timing;

    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        bit hp; bit vp;
    } tim_t;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic de, hs, vs, nb, fs;
    } obs_t;

    typedef struct packed {
        obs_t a;
        obs_t b;
    } pair_t;

    localparam tim_t T0 = '{ha:1280, hf:48, hs:112, hb:248, va:1024, vf:1, vs:3, vb:38, hp:1'b1, vp:1'b1};
    localparam tim_t T1 = '{ha:4, hf:1, hs:2, hb:1, va:3, vf:1, vs:1, vb:1, hp:1'b0, vp:1'b1};

    logic clk = 1'b0;
    logic rst0 = 1'b0;
    logic rst1 = 1'b0;
    always #5 clk = ~clk;

    logic [10:0] x0, y0, x1, y1;
    logic de0, hs0, vs0, nb0, fs0;
    logic de1, hs1, vs1, nb1, fs1;

    vga_timing dut0 (
        .VGA_CLK (clk), .reset (rst0), .x (x0), .y (y0), .disp_en (de0),
        .h_sync (hs0), .v_sync (vs0), .n_blank (nb0), .frame_start (fs0)
    );

    vga_timing #(
        .H_ACTIVE (T1.ha), .H_FP (T1.hf), .H_SYNC (T1.hs), .H_BP (T1.hb),
        .V_ACTIVE (T1.va), .V_FP (T1.vf), .V_SYNC (T1.vs), .V_BP (T1.vb),
        .H_POL (T1.hp), .V_POL (T1.vp)
    ) dut1 (
        .VGA_CLK (clk), .reset (rst1), .x (x1), .y (y1), .disp_en (de1),
        .h_sync (hs1), .v_sync (vs1), .n_blank (nb1), .frame_start (fs1)
    );

    int n_vec = 0;
    int n_bad = 0;
    pair_t sb[$];

    // Pixel t after reset release lands at x = t mod H_TOTAL, y = (t div H_TOTAL) mod V_TOTAL.
    function automatic obs_t ref_at(input int t, input tim_t p);
        obs_t o;
        int ht, vt, xx, yy;
        ht   = p.ha + p.hf + p.hs + p.hb;
        vt   = p.va + p.vf + p.vs + p.vb;
        xx   = t % ht;
        yy   = (t / ht) % vt;
        o.x  = 11'(xx);
        o.y  = 11'(yy);
        o.de = (xx < p.ha) && (yy < p.va);
        o.hs = (xx >= p.ha + p.hf && xx < p.ha + p.hf + p.hs) ? p.hp : !p.hp;
        o.vs = (yy >= p.va + p.vf && yy < p.va + p.vf + p.vs) ? p.vp : !p.vp;
        o.nb = o.de;
        o.fs = (xx == 0) && (yy == 0);
        return o;
    endfunction

    function automatic obs_t rst_obs(input tim_t p);
        obs_t o;
        o    = '0;
        o.hs = !p.hp;
        o.vs = !p.vp;
        return o;
    endfunction

    int   mt[2]   = '{0, 0};
    bit   mrst[2] = '{1'b0, 1'b0};
    obs_t mprev[2];

    task automatic model_step(input int i, input bit rst_now, input tim_t p, output obs_t e);
        obs_t u;
        if (!rst_now || !mrst[i]) begin
            // in reset, or released after this edge: outputs still at reset values
            e        = rst_obs(p);
            mt[i]    = 0;
            mprev[i] = e;
        end else begin
            u = ref_at(mt[i], p);
            mt[i]++;
            e = u;
`ifdef VGA_TIMING_SYNC_DELAY_EN
            e.hs = mprev[i].hs;
            e.vs = mprev[i].vs;
            e.nb = mprev[i].nb;
`endif
            mprev[i] = u;
        end
        mrst[i] = rst_now;
    endtask

    task automatic cyc(input bit r0, input bit r1);
        pair_t pr;
        @(posedge clk);
        #2;
        rst0 = r0;
        rst1 = r1;
        model_step(0, r0, T0, pr.a);
        model_step(1, r1, T1, pr.b);
        sb.push_back(pr);
    endtask

    task automatic chk(input string inst, input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s.%s got %0d want %0d at %0t", inst, name, got, want, $time);
        end
    endtask

    task automatic chk_obs(input string inst, input obs_t g, input obs_t e);
        chk(inst, "x", int'(g.x), int'(e.x));
        chk(inst, "y", int'(g.y), int'(e.y));
        chk(inst, "disp_en", int'(g.de), int'(e.de));
        chk(inst, "h_sync", int'(g.hs), int'(e.hs));
        chk(inst, "v_sync", int'(g.vs), int'(e.vs));
        chk(inst, "n_blank", int'(g.nb), int'(e.nb));
        chk(inst, "frame_start", int'(g.fs), int'(e.fs));
    endtask

    always @(negedge clk) begin
        pair_t pr;
        obs_t  g0, g1;
        if (sb.size() > 0) begin
            pr = sb.pop_front();
            g0 = '{x:x0, y:y0, de:de0, hs:hs0, vs:vs0, nb:nb0, fs:fs0};
            g1 = '{x:x1, y:y1, de:de1, hs:hs1, vs:vs1, nb:nb1, fs:fs1};
            chk_obs("dflt", g0, pr.a);
            chk_obs("tiny", g1, pr.b);
        end
    end

    initial begin
        int n_cyc, r0_at, r0_len, r1_hold;
        bit r0, r1;
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);
        n_cyc   = 3 * 1688 + 600;
        r0_at   = 1688 + 600 + int'($urandom_range(0, 200));
        r0_len  = int'($urandom_range(1, 3));
        r1_hold = 0;
        for (int c = 0; c < n_cyc; c++) begin
            r0 = !(c >= r0_at && c < r0_at + r0_len);
            if (r1_hold > 0) begin
                r1_hold--;
                r1 = 1'b0;
            end else if (c > 200 && $urandom_range(0, 59) == 0) begin
                r1_hold = int'($urandom_range(0, 3));
                r1 = 1'b0;
            end else begin
                r1 = 1'b1;
            end
            cyc(r0, r1);
        end
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending %0d want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
